// File: rtl/irq_prio_ctrl_pkg.sv
// Shared types and constants for the irq_prio_ctrl interrupt controller:
// FSM state encoding, status byte bit positions and the source-count limit.
package irq_prio_pkg;

    localparam int IRQ_MAX_SRC = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam int ST_INT_EN = 7;
    localparam int ST_REQ    = 6;
    localparam int ST_SVC    = 5;
    localparam int ST_PEND   = 4;
    localparam int ST_SPUR   = 3;
    localparam int ST_OVR    = 2;

endpackage

// File: rtl/irq_prio_ctrl_prio_enc.sv
// Combinational priority encoder: idx is the highest set index of req,
// valid is high when any request bit is set.
module prio_enc_param #(
    parameter  int N  = 16,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Ascending scan so the last (highest) set bit wins.
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = 0; i < N; i++) begin
            if (req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt controller: pending/mask registers, highest-index arbitration and a
// req/ack/eoi handshake FSM. Define IRQ_EDGE_TRIG_EN for rising-edge pending capture.
module irq_prio_ctrl
    import irq_prio_pkg::*;
#(
    parameter  int NUM_SRC = 16,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               int_en,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               status_clr,
    input  logic               irq_ack,
    input  logic               eoi,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [7:0]         status
);

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, mask_q, prev_q;
    logic [ID_W-1:0]    id_q, id_d;
    logic               int_en_q, spur_q, ovr_q;

    logic [NUM_SRC-1:0] set_vec, clr_vec, elig;
    logic [ID_W-1:0]    sel_id;
    logic               sel_valid, ack_ok, spur_evt, ovr_evt;

`ifdef IRQ_EDGE_TRIG_EN
    assign set_vec = irq_in & ~prev_q;
`else
    assign set_vec = irq_in;
`endif

    assign elig    = pend_q & mask_q & {NUM_SRC{int_en}};
    assign ack_ok  = (state_q == REQ) && irq_ack;
    assign clr_vec = ack_ok ? (NUM_SRC'(1) << id_q) : '0;

    assign spur_evt = (irq_ack && (state_q != REQ)) || (eoi && (state_q != SERVICE));
    // A fresh assertion onto a bit that was never serviced.
    assign ovr_evt  = |(set_vec & pend_q & ~prev_q);

    prio_enc_param #(.N(NUM_SRC)) u_prio_enc (
        .req   (elig),
        .idx   (sel_id),
        .valid (sel_valid)
    );

    // Once in REQ the presented id is frozen; nothing retracts it.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = REQ;
                    id_d    = sel_id;
                end
            end
            REQ:     if (irq_ack) state_d = SERVICE;
            SERVICE: if (eoi)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            id_q     <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            prev_q   <= '0;
            int_en_q <= 1'b0;
            spur_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            pend_q   <= (pend_q & ~clr_vec) | set_vec;
            if (mask_we) mask_q <= mask_wdata;
            prev_q   <= irq_in;
            int_en_q <= int_en;
            spur_q   <= spur_evt | (spur_q & ~status_clr);
            ovr_q    <= ovr_evt  | (ovr_q  & ~status_clr);
        end
    end

    assign irq_req = (state_q == REQ);
    assign irq_id  = id_q;
    assign pending = pend_q;

    always_comb begin
        status            = 8'h00;
        status[ST_INT_EN] = int_en_q;
        status[ST_REQ]    = (state_q == REQ);
        status[ST_SVC]    = (state_q == SERVICE);
        status[ST_PEND]   = |pend_q;
        status[ST_SPUR]   = spur_q;
        status[ST_OVR]    = ovr_q;
        status[1:0]       = state_q;
    end

endmodule
